// File: rtl/vram_fill_engine.sv
// Rectangle-fill initiator for the GPU VRAM write port: clips the programmed
// rectangle to the visible area and issues one pixel write per cycle, row-major.
module vram_fill_engine #(
  parameter int H_RES  = 200,
  parameter int V_RES  = 150,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [7:0]        x0_i,
  input  logic [7:0]        y0_i,
  input  logic [7:0]        w_i,
  input  logic [7:0]        h_i,
  input  logic [DATA_W-1:0] color_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              v_we_o,
  output logic [15:0]       v_addr_o,
  output logic [DATA_W-1:0] v_data_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CLIP = 2'd1;
  localparam logic [1:0] FILL = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [8:0] H_LIM = 9'(H_RES);
  localparam logic [8:0] V_LIM = 9'(V_RES);

  logic [1:0]        state_q, state_d;
  logic [7:0]        x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
  logic [DATA_W-1:0] color_q, color_d;
  logic [8:0]        x_end_q, x_end_d, y_end_q, y_end_d;
  logic [7:0]        x_q, x_d, y_q, y_d;
  logic [DATA_W-1:0] v_data_q, v_data_d;
  logic              busy_q, busy_d, done_q, done_d, v_we_q, v_we_d;

  logic [8:0] x_sum, y_sum, x_lim, y_lim;
  logic       empty, at_row_end, at_last;

  // Clip arithmetic is 9 bits wide so x0+w never wraps past 255.
  always_comb begin
    x_sum      = {1'b0, x0_q} + {1'b0, w_q};
    y_sum      = {1'b0, y0_q} + {1'b0, h_q};
    x_lim      = (x_sum > H_LIM) ? H_LIM : x_sum;
    y_lim      = (y_sum > V_LIM) ? V_LIM : y_sum;
    empty      = ({1'b0, x0_q} >= H_LIM) || ({1'b0, y0_q} >= V_LIM) ||
                 (w_q == 8'd0) || (h_q == 8'd0);
    at_row_end = ({1'b0, x_q} == x_end_q);
    at_last    = at_row_end && ({1'b0, y_q} == y_end_q);
  end

  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    w_d      = w_q;
    h_d      = h_q;
    color_d  = color_q;
    x_end_d  = x_end_q;
    y_end_d  = y_end_q;
    x_d      = x_q;
    y_d      = y_q;
    v_data_d = v_data_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          x0_d    = x0_i;
          y0_d    = y0_i;
          w_d     = w_i;
          h_d     = h_i;
          color_d = color_i;
          state_d = CLIP;
        end
      end
      CLIP: begin
        x_end_d = x_lim - 9'd1;
        y_end_d = y_lim - 9'd1;
        if (abort_i || empty) begin
          state_d = DONE;
        end else begin
          // The pixel counters double as the address register, so they
          // are only loaded when a write is actually about to happen.
          x_d      = x0_q;
          y_d      = y0_q;
          v_data_d = color_q;
          state_d  = FILL;
        end
      end
      FILL: begin
        if (abort_i || at_last) begin
          state_d = DONE;
        end else if (at_row_end) begin
          x_d = x0_q;
          y_d = y_q + 8'd1;
        end else begin
          x_d = x_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    v_we_d = (state_d == FILL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      color_q  <= '0;
      x_end_q  <= '0;
      y_end_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      v_data_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      v_we_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      w_q      <= w_d;
      h_q      <= h_d;
      color_q  <= color_d;
      x_end_q  <= x_end_d;
      y_end_q  <= y_end_d;
      x_q      <= x_d;
      y_q      <= y_d;
      v_data_q <= v_data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      v_we_q   <= v_we_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign v_we_o   = v_we_q;
  assign v_addr_o = {y_q, x_q};
  assign v_data_o = v_data_q;

endmodule

// File: tb/tb_vram_fill_engine.sv
// Self-checking bench for vram_fill_engine: a per-cycle expected trace is built
// from the clipped rectangle geometry and compared against the captured outputs.
module tb_vram_fill_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0, abort_i = 1'b0;
  logic [7:0]  x0_i = '0, y0_i = '0, w_i = '0, h_i = '0, color_i = '0;
  logic        busy_o, done_o, v_we_o;
  logic [15:0] v_addr_o;
  logic [7:0]  v_data_o;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] hold_addr = '0;
  logic [7:0]  hold_data = '0;

  // Control triplets are {we, done, busy}; index 0 is cycle k+1.
  logic [2:0]  exp_ctl[$], cap_ctl[$];
  logic [15:0] exp_addr[$], cap_addr[$];
  logic [7:0]  exp_data[$], cap_data[$];

  vram_fill_engine #(.H_RES(200), .V_RES(150), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .x0_i(x0_i), .y0_i(y0_i), .w_i(w_i), .h_i(h_i), .color_i(color_i),
    .busy_o(busy_o), .done_o(done_o), .v_we_o(v_we_o),
    .v_addr_o(v_addr_o), .v_data_o(v_data_o)
  );

  always #5 clk = ~clk;

  // Reference: list of pixels inside the visible area, then a cycle trace.
  task automatic model_fill(input int x0, input int y0, input int w, input int h,
                            input logic [7:0] col, input int abort_cyc);
    int cw, ch, last;
    logic [15:0] wr[$];
    exp_ctl.delete(); exp_addr.delete(); exp_data.delete();
    cw = (x0 >= 200 || w == 0) ? 0 : ((x0 + w > 200) ? 200 - x0 : w);
    ch = (y0 >= 150 || h == 0) ? 0 : ((y0 + h > 150) ? 150 - y0 : h);
    if (cw == 0) ch = 0;
    if (ch == 0) cw = 0;
    for (int yy = 0; yy < ch; yy++)
      for (int xx = 0; xx < cw; xx++)
        wr.push_back({8'(y0 + yy), 8'(x0 + xx)});
    last = 1 + cw * ch;
    if (abort_cyc > 0 && abort_cyc < last) last = abort_cyc;
    for (int c = 1; c <= last + 1; c++) begin
      if (c >= 2 && c <= last) begin
        hold_addr = wr[c-2];
        hold_data = col;
        exp_ctl.push_back(3'b101);
      end else if (c == last + 1) begin
        exp_ctl.push_back(3'b011);
      end else begin
        exp_ctl.push_back(3'b001);
      end
      exp_addr.push_back(hold_addr);
      exp_data.push_back(hold_data);
    end
  endtask

  task automatic issue_start(input int x0, input int y0, input int w, input int h,
                             input logic [7:0] col, input logic with_abort);
    @(negedge clk);
    x0_i = x0[7:0]; y0_i = y0[7:0]; w_i = w[7:0]; h_i = h[7:0]; color_i = col;
    start_i = 1'b1;
    abort_i = with_abort;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    abort_i = 1'b0;
  endtask

  task automatic capture(input int budget);
    cap_ctl.delete(); cap_addr.delete(); cap_data.delete();
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      cap_ctl.push_back({v_we_o, done_o, busy_o});
      cap_addr.push_back(v_addr_o);
      cap_data.push_back(v_data_o);
      if (done_o) break;
    end
  endtask

  task automatic abort_at(input int cyc);
    if (cyc > 0) begin
      repeat (cyc) @(negedge clk);
      #2 abort_i = 1'b1;
      @(posedge clk);
      #1 abort_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if ({busy_o, done_o, v_we_o, v_addr_o, v_data_o} !== 27'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %h, expected 0",
               {busy_o, done_o, v_we_o, v_addr_o, v_data_o});
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({busy_o, done_o, v_we_o, v_addr_o, v_data_o} !== 27'd0) begin
      miscompares++;
      $display("[TB] FAIL idle_after_reset: got %h, expected 0",
               {busy_o, done_o, v_we_o, v_addr_o, v_data_o});
    end
    hold_addr = '0;
    hold_data = '0;
  endtask

  task automatic test_basic();
    model_fill(10, 20, 2, 2, 8'hE0, 0);
    issue_start(10, 20, 2, 2, 8'hE0, 1'b0);
    capture(100);
    vectors++;
    if (cap_ctl.size() != exp_ctl.size()) begin
      miscompares++;
      $display("[TB] FAIL basic_len: got %0d cycles, expected %0d", cap_ctl.size(), exp_ctl.size());
    end
    for (int i = 0; i < exp_ctl.size() && i < cap_ctl.size(); i++) begin
      vectors++;
      if (cap_ctl[i] !== exp_ctl[i] || cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin
        miscompares++;
        $display("[TB] FAIL basic k+%0d: got ctl=%b addr=%h data=%h, expected ctl=%b addr=%h data=%h",
                 i + 1, cap_ctl[i], cap_addr[i], cap_data[i], exp_ctl[i], exp_addr[i], exp_data[i]);
      end
    end
    @(negedge clk);
    vectors++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL basic_idle: got busy=%b done=%b, expected 0 0", busy_o, done_o);
    end
  endtask

  task automatic test_clip_and_empty();
    int cx[3] = '{198, 10, 200};
    int cy[3] = '{149, 20, 5};
    int cwd[3] = '{5, 0, 4};
    int cht[3] = '{3, 7, 4};
    for (int t = 0; t < 3; t++) begin
      model_fill(cx[t], cy[t], cwd[t], cht[t], 8'h3C, 0);
      issue_start(cx[t], cy[t], cwd[t], cht[t], 8'h3C, 1'b0);
      capture(100);
      vectors++;
      if (cap_ctl.size() != exp_ctl.size()) begin
        miscompares++;
        $display("[TB] FAIL clip%0d_len: got %0d cycles, expected %0d", t, cap_ctl.size(), exp_ctl.size());
      end
      for (int i = 0; i < exp_ctl.size() && i < cap_ctl.size(); i++) begin
        vectors++;
        if (cap_ctl[i] !== exp_ctl[i] || cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin
          miscompares++;
          $display("[TB] FAIL clip%0d k+%0d: got ctl=%b addr=%h data=%h, expected ctl=%b addr=%h data=%h",
                   t, i + 1, cap_ctl[i], cap_addr[i], cap_data[i], exp_ctl[i], exp_addr[i], exp_data[i]);
        end
      end
    end
  endtask

  task automatic test_full_screen();
    model_fill(0, 0, 200, 150, 8'h5A, 0);
    issue_start(0, 0, 200, 150, 8'h5A, 1'b0);
    capture(31000);
    vectors++;
    if (cap_ctl.size() != exp_ctl.size()) begin
      miscompares++;
      $display("[TB] FAIL full_len: got %0d cycles, expected %0d", cap_ctl.size(), exp_ctl.size());
    end
    for (int i = 0; i < exp_ctl.size() && i < cap_ctl.size(); i++) begin
      vectors++;
      if (cap_ctl[i] !== exp_ctl[i] || cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin
        miscompares++;
        $display("[TB] FAIL full k+%0d: got ctl=%b addr=%h data=%h, expected ctl=%b addr=%h data=%h",
                 i + 1, cap_ctl[i], cap_addr[i], cap_data[i], exp_ctl[i], exp_addr[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_back_to_back_start();
    model_fill(10, 20, 2, 2, 8'hE0, 0);
    issue_start(10, 20, 2, 2, 8'hE0, 1'b0);
    fork
      capture(100);
      begin
        repeat (3) @(negedge clk);
        #2;
        x0_i = 8'd50; y0_i = 8'd60; w_i = 8'd9; h_i = 8'd9; color_i = 8'h11;
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
      end
    join
    vectors++;
    if (cap_ctl.size() != exp_ctl.size()) begin
      miscompares++;
      $display("[TB] FAIL restart_len: got %0d cycles, expected %0d", cap_ctl.size(), exp_ctl.size());
    end
    for (int i = 0; i < exp_ctl.size() && i < cap_ctl.size(); i++) begin
      vectors++;
      if (cap_ctl[i] !== exp_ctl[i] || cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin
        miscompares++;
        $display("[TB] FAIL restart k+%0d: got ctl=%b addr=%h data=%h, expected ctl=%b addr=%h data=%h",
                 i + 1, cap_ctl[i], cap_addr[i], cap_data[i], exp_ctl[i], exp_addr[i], exp_data[i]);
      end
    end
    @(negedge clk);
    vectors++;
    if (busy_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL restart_idle: got busy=%b, expected 0", busy_o);
    end
  endtask

  task automatic test_abort();
    logic seen;
    // Abort sampled at the end of the second write cycle; start+abort together in IDLE.
    for (int t = 0; t < 2; t++) begin
      model_fill(10, 20, 2, 2, 8'hE0, (t == 0) ? 3 : 0);
      issue_start(10, 20, 2, 2, 8'hE0, (t == 1));
      fork
        capture(100);
        abort_at((t == 0) ? 3 : 0);
      join
      vectors++;
      if (cap_ctl.size() != exp_ctl.size()) begin
        miscompares++;
        $display("[TB] FAIL abort%0d_len: got %0d cycles, expected %0d", t, cap_ctl.size(), exp_ctl.size());
      end
      for (int i = 0; i < exp_ctl.size() && i < cap_ctl.size(); i++) begin
        vectors++;
        if (cap_ctl[i] !== exp_ctl[i] || cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin
          miscompares++;
          $display("[TB] FAIL abort%0d k+%0d: got ctl=%b addr=%h data=%h, expected ctl=%b addr=%h data=%h",
                   t, i + 1, cap_ctl[i], cap_addr[i], cap_data[i], exp_ctl[i], exp_addr[i], exp_data[i]);
        end
      end
    end
    @(negedge clk) abort_i = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (busy_o || done_o || v_we_o) seen = 1'b1;
    end
    abort_i = 1'b0;
    vectors++;
    if (seen) begin
      miscompares++;
      $display("[TB] FAIL abort_idle: got activity=1, expected 0");
    end
  endtask

  task automatic test_reset_mid_fill();
    logic seen;
    issue_start(10, 20, 2, 2, 8'hE0, 1'b0);
    repeat (4) @(negedge clk);
    vectors++;
    if ({v_we_o, v_addr_o, v_data_o} !== {1'b1, 16'h150A, 8'hE0}) begin
      miscompares++;
      $display("[TB] FAIL third_write: got %h, expected %h", {v_we_o, v_addr_o, v_data_o},
               {1'b1, 16'h150A, 8'hE0});
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy_o, done_o, v_we_o, v_addr_o, v_data_o} !== 27'd0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got %h, expected 0", {busy_o, done_o, v_we_o, v_addr_o, v_data_o});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (v_we_o || busy_o || done_o) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("[TB] FAIL resume_after_reset: got activity=1, expected 0");
    end
    hold_addr = '0;
    hold_data = '0;
  endtask

  task automatic test_random();
    int x0, y0, w, h, ab;
    logic [7:0] col;
    for (int t = 0; t < 20; t++) begin
      x0 = $urandom_range(0, 215);
      y0 = $urandom_range(0, 160);
      w  = $urandom_range(0, 30);
      h  = $urandom_range(0, 30);
      if ($urandom_range(0, 3) == 0) begin
        w = $urandom_range(200, 255);
        h = $urandom_range(0, 2);
      end
      col = 8'($urandom);
      ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : 0;
      model_fill(x0, y0, w, h, col, ab);
      issue_start(x0, y0, w, h, col, 1'b0);
      fork
        capture(31000);
        abort_at(ab);
      join
      vectors++;
      if (cap_ctl.size() != exp_ctl.size()) begin
        miscompares++;
        $display("[TB] FAIL rand%0d_len: got %0d cycles, expected %0d", t, cap_ctl.size(), exp_ctl.size());
      end
      for (int i = 0; i < exp_ctl.size() && i < cap_ctl.size(); i++) begin
        vectors++;
        if (cap_ctl[i] !== exp_ctl[i] || cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin
          miscompares++;
          $display("[TB] FAIL rand%0d k+%0d: got ctl=%b addr=%h data=%h, expected ctl=%b addr=%h data=%h",
                   t, i + 1, cap_ctl[i], cap_addr[i], cap_data[i], exp_ctl[i], exp_addr[i], exp_data[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clip_and_empty();
    test_back_to_back_start();
    test_abort();
    test_reset_mid_fill();
    test_full_screen();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
